decode_cycle: RTL and testbench

//  SimpleRISC decode stage, directly downstream of fetch_cycle.
//  - Consumes instruction_D/pc_D; reads the register file; builds the immediate, branch target and control flags.
//  - Registers everything into the D->E pipeline register.
//  - Owns load-use hazard detection and drives add_stall back to fetch.

---
 rtl/decode_cycle_pkg.sv | 78 +++++++
 rtl/decode_cycle_if.sv | 47 ++++
 rtl/decode_cycle_register_file.sv | 53 +++++
 rtl/decode_cycle.sv | 139 +++++++++++++
 tb/tb_decode_cycle.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_cycle_pkg.sv
// Shared definitions for the SimpleRISC decode stage: opcodes, register
// indices, immediate modifier codes and the D->E pipeline register layout.
package decode_cycle_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h6800_0000;
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_0FFC;

    localparam logic [3:0] RA_IDX = 4'd15;
    localparam logic [3:0] SP_IDX = 4'd14;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef enum logic [1:0] {
        MOD_SEXT = 2'b00,
        MOD_ZEXT = 2'b01,
        MOD_HIGH = 2'b10,
        MOD_RSVD = 2'b11
    } mod_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] btgt;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [4:0]  opcode;
        logic        is_imm;
        logic        is_wb;
        logic        is_ld;
        logic        is_st;
        logic        is_beq;
        logic        is_bgt;
        logic        is_ubr;
        logic        is_ret;
        logic        is_call;
    } de_reg_t;

    // Bubble: everything cleared except the opcode, which reads as nop.
    function automatic de_reg_t bubble_reg();
        de_reg_t b;
        b        = '0;
        b.opcode = OP_NOP;
        return b;
    endfunction

    // Reserved modifier behaves like plain sign extension.
    function automatic logic [31:0] build_imm(input mod_e mod, input logic [15:0] imm16);
        case (mod)
            MOD_ZEXT: return {16'h0000, imm16};
            MOD_HIGH: return {imm16, 16'h0000};
            default:  return {{16{imm16[15]}}, imm16};
        endcase
    endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: fetch/writeback inputs, stall request and D->E outputs.
// master = environment (fetch, writeback, execute), slave = decode_cycle.
interface decode_cycle_if;
    logic        interrupt;
    logic        isbranchtaken_E;
    logic [31:0] instruction_D;
    logic [31:0] pc_D;
    logic        regwrite_W;
    logic [3:0]  rd_W;
    logic [31:0] result_W;

    logic        add_stall;
    logic [31:0] pc_E;
    logic [31:0] op1_E;
    logic [31:0] op2_E;
    logic [31:0] imm_E;
    logic [31:0] branchtarget_E;
    logic [3:0]  rd_E;
    logic [3:0]  rs1_E;
    logic [3:0]  rs2_E;
    logic [4:0]  opcode_E;
    logic        isImmediate_E;
    logic        isWb_E;
    logic        isLd_E;
    logic        isSt_E;
    logic        isBeq_E;
    logic        isBgt_E;
    logic        isUBranch_E;
    logic        isRet_E;
    logic        isCall_E;

    modport master (
        output interrupt, isbranchtaken_E, instruction_D, pc_D,
               regwrite_W, rd_W, result_W,
        input  add_stall, pc_E, op1_E, op2_E, imm_E, branchtarget_E,
               rd_E, rs1_E, rs2_E, opcode_E, isImmediate_E, isWb_E, isLd_E,
               isSt_E, isBeq_E, isBgt_E, isUBranch_E, isRet_E, isCall_E
    );

    modport slave (
        input  interrupt, isbranchtaken_E, instruction_D, pc_D,
               regwrite_W, rd_W, result_W,
        output add_stall, pc_E, op1_E, op2_E, imm_E, branchtarget_E,
               rd_E, rs1_E, rs2_E, opcode_E, isImmediate_E, isWb_E, isLd_E,
               isSt_E, isBeq_E, isBgt_E, isUBranch_E, isRet_E, isCall_E
    );
endinterface

// File: rtl/decode_cycle_register_file.sv
// 16x32 register file: two combinational read ports, one synchronous write
// port, synchronous reset (sp preset to SP_INIT, others zero).
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback data is forwarded
// onto a matching read port (write-through).
module register_file
    import decode_cycle_pkg::*;
#(
    parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];

    // Next-state of the array: apply the writeback, if any.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end
    end

    // Reset wins over a writeback in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= (4'(i) == SP_IDX) ? SP_INIT : 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == ra1)) rd1 = wd;
        if (we && (wa == ra2)) rd2 = wd;
`endif
    end

endmodule

// File: rtl/decode_cycle.sv
// SimpleRISC decode stage: field/immediate/branch-target decode, register
// file read, load-use hazard detection and the D->E pipeline register.
// Optional macro REGFILE_BYPASS_EN (forwarded to the register file).
module decode_cycle
    import decode_cycle_pkg::*;
#(
    parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);

    logic [4:0]  opcode;
    logic        i_bit;
    logic [3:0]  rd_f;
    logic [3:0]  rs1_f;
    logic [3:0]  rs2_f;
    logic [15:0] imm16;
    logic [26:0] off;

    logic        is_alu, is_ld, is_st, is_beq, is_bgt, is_b, is_call, is_ret;
    logic        is_mov, is_not, is_cmp;
    logic        src1, src2;
    logic [3:0]  rs1_s, rs2_s;
    logic [31:0] rf_rd1, rf_rd2;
    logic        flush, stall;

    de_reg_t dec;
    de_reg_t de_d;
    de_reg_t de_q;

    assign opcode = bus.instruction_D[31:27];
    assign i_bit  = bus.instruction_D[26];
    assign rd_f   = bus.instruction_D[25:22];
    assign rs1_f  = bus.instruction_D[21:18];
    assign rs2_f  = bus.instruction_D[17:14];
    assign imm16  = bus.instruction_D[15:0];
    assign off    = bus.instruction_D[26:0];

    // Instruction class, effective source indices and source usage.
    always_comb begin
        is_alu  = (opcode <= OP_ASR);
        is_ld   = (opcode == OP_LD);
        is_st   = (opcode == OP_ST);
        is_beq  = (opcode == OP_BEQ);
        is_bgt  = (opcode == OP_BGT);
        is_b    = (opcode == OP_B);
        is_call = (opcode == OP_CALL);
        is_ret  = (opcode == OP_RET);
        is_mov  = (opcode == OP_MOV);
        is_not  = (opcode == OP_NOT);
        is_cmp  = (opcode == OP_CMP);
        // ret reads the return address; st reads its data register through port 2.
        rs1_s   = is_ret ? RA_IDX : rs1_f;
        rs2_s   = is_st  ? rd_f   : rs2_f;
        src1    = (is_alu & ~is_mov & ~is_not) | is_ld | is_st | is_ret;
        src2    = (is_alu & ~i_bit) | is_st;
    end

    register_file #(.SP_INIT(SP_INIT)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_s),
        .ra2 (rs2_s),
        .we  (bus.regwrite_W),
        .wa  (bus.rd_W),
        .wd  (bus.result_W),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    // Assemble the decoded D->E payload.
    always_comb begin
        dec         = '0;
        dec.pc      = bus.pc_D;
        dec.op1     = rf_rd1;
        dec.op2     = rf_rd2;
        dec.imm     = build_imm(mod_e'(bus.instruction_D[17:16]), imm16);
        dec.btgt    = bus.pc_D + {{3{off[26]}}, off, 2'b00};
        dec.rd      = is_call ? RA_IDX : rd_f;
        dec.rs1     = rs1_s;
        dec.rs2     = rs2_s;
        dec.opcode  = opcode;
        dec.is_imm  = i_bit & (is_alu | is_ld | is_st);
        dec.is_wb   = (is_alu & ~is_cmp) | is_ld | is_call;
        dec.is_ld   = is_ld;
        dec.is_st   = is_st;
        dec.is_beq  = is_beq;
        dec.is_bgt  = is_bgt;
        dec.is_ubr  = is_b | is_call | is_ret;
        dec.is_ret  = is_ret;
        dec.is_call = is_call;
    end

    // A taken branch or interrupt squashes the stall: the instruction in D is dead anyway.
    assign flush = bus.isbranchtaken_E | bus.interrupt;
    assign stall = de_q.is_ld
                 & ((src1 & (rs1_s == de_q.rd)) | (src2 & (rs2_s == de_q.rd)))
                 & ~flush;

    // Flush and stall both insert a bubble; otherwise take the decoded payload.
    always_comb begin
        de_d = dec;
        if (flush || stall) begin
            de_d = bubble_reg();
        end
    end

    // D->E pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= bubble_reg();
        end else begin
            de_q <= de_d;
        end
    end

    assign bus.add_stall      = stall;
    assign bus.pc_E           = de_q.pc;
    assign bus.op1_E          = de_q.op1;
    assign bus.op2_E          = de_q.op2;
    assign bus.imm_E          = de_q.imm;
    assign bus.branchtarget_E = de_q.btgt;
    assign bus.rd_E           = de_q.rd;
    assign bus.rs1_E          = de_q.rs1;
    assign bus.rs2_E          = de_q.rs2;
    assign bus.opcode_E       = de_q.opcode;
    assign bus.isImmediate_E  = de_q.is_imm;
    assign bus.isWb_E         = de_q.is_wb;
    assign bus.isLd_E         = de_q.is_ld;
    assign bus.isSt_E         = de_q.is_st;
    assign bus.isBeq_E        = de_q.is_beq;
    assign bus.isBgt_E        = de_q.is_bgt;
    assign bus.isUBranch_E    = de_q.is_ubr;
    assign bus.isRet_E        = de_q.is_ret;
    assign bus.isCall_E       = de_q.is_call;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: instruction-level reference model checked every
// cycle, plus hand-computed literal checks on the directed scenarios.
module tb_decode_cycle;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   chk_en;

    decode_cycle_if bus ();

    decode_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, op1, op2, imm, btgt;
        logic [3:0]  rd, rs1, rs2;
        logic [4:0]  opcode;
        bit          imm_f, wb, ld, st, beq, bgt, ubr, ret, call;
    } e_t;

    logic [31:0] mrf [16];
    e_t          exp_e;

    function automatic e_t mbubble();
        e_t e;
        e.pc = 0; e.op1 = 0; e.op2 = 0; e.imm = 0; e.btgt = 0;
        e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.opcode = 5'd13;
        e.imm_f = 0; e.wb = 0; e.ld = 0; e.st = 0; e.beq = 0; e.bgt = 0;
        e.ubr = 0; e.ret = 0; e.call = 0;
        return e;
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (bus.regwrite_W && bus.rd_W == idx) return bus.result_W;
`endif
        return mrf[idx];
    endfunction

    // Which registers an instruction reads, from the source-use table.
    function automatic void msrc(input logic [31:0] ins, output bit u1, output bit u2,
                                 output logic [3:0] r1, output logic [3:0] r2);
        int op;
        op = int'(ins[31:27]);
        r1 = (op == 20) ? 4'd15 : ins[21:18];
        r2 = (op == 15) ? ins[25:22] : ins[17:14];
        u1 = (op inside {[0:7], [10:12], 14, 15, 20});
        u2 = ((op <= 12) && !ins[26]) || (op == 15);
    endfunction

    function automatic bit mstall();
        bit u1, u2;
        logic [3:0] r1, r2;
        msrc(bus.instruction_D, u1, u2, r1, r2);
        if (!exp_e.ld || bus.isbranchtaken_E || bus.interrupt) return 0;
        return (u1 && r1 == exp_e.rd) || (u2 && r2 == exp_e.rd);
    endfunction

    function automatic e_t mdec(input logic [31:0] ins, input logic [31:0] pc);
        e_t e;
        int op;
        bit u1, u2;
        logic [3:0] r1, r2;
        logic signed [31:0] soff;
        op = int'(ins[31:27]);
        msrc(ins, u1, u2, r1, r2);
        e = mbubble();
        e.pc     = pc;
        e.opcode = ins[31:27];
        e.rs1    = r1;
        e.rs2    = r2;
        e.op1    = mread(r1);
        e.op2    = mread(r2);
        e.rd     = (op == 19) ? 4'd15 : ins[25:22];
        case (ins[17:16])
            2'd1:    e.imm = {16'h0, ins[15:0]};
            2'd2:    e.imm = {ins[15:0], 16'h0};
            default: e.imm = {{16{ins[15]}}, ins[15:0]};
        endcase
        soff   = $signed({{5{ins[26]}}, ins[26:0]});
        e.btgt = pc + soff * 4;
        e.imm_f = ins[26] && (op <= 15) && (op != 13);
        e.wb    = (op <= 12 && op != 5) || op == 14 || op == 19;
        e.ld    = (op == 14);
        e.st    = (op == 15);
        e.beq   = (op == 16);
        e.bgt   = (op == 17);
        e.ubr   = (op >= 18 && op <= 20);
        e.ret   = (op == 20);
        e.call  = (op == 19);
        return e;
    endfunction

    // Reference model: advance the E register and register file each edge.
    always @(posedge clk) begin
        e_t nxt;
        if (rst || bus.isbranchtaken_E || bus.interrupt || mstall())
            nxt = mbubble();
        else
            nxt = mdec(bus.instruction_D, bus.pc_D);
        if (rst) begin
            for (int i = 0; i < 16; i++) mrf[i] = (i == 14) ? 32'h0FFC : 32'h0;
        end else if (bus.regwrite_W) begin
            mrf[bus.rd_W] = bus.result_W;
        end
        exp_e = nxt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_E",           bus.pc_E,                  exp_e.pc);
            chk("op1_E",          bus.op1_E,                 exp_e.op1);
            chk("op2_E",          bus.op2_E,                 exp_e.op2);
            chk("imm_E",          bus.imm_E,                 exp_e.imm);
            chk("branchtarget_E", bus.branchtarget_E,        exp_e.btgt);
            chk("rd_E",           32'(bus.rd_E),             32'(exp_e.rd));
            chk("rs1_E",          32'(bus.rs1_E),            32'(exp_e.rs1));
            chk("rs2_E",          32'(bus.rs2_E),            32'(exp_e.rs2));
            chk("opcode_E",       32'(bus.opcode_E),         32'(exp_e.opcode));
            chk("isImmediate_E",  32'(bus.isImmediate_E),    32'(exp_e.imm_f));
            chk("isWb_E",         32'(bus.isWb_E),           32'(exp_e.wb));
            chk("isLd_E",         32'(bus.isLd_E),           32'(exp_e.ld));
            chk("isSt_E",         32'(bus.isSt_E),           32'(exp_e.st));
            chk("isBeq_E",        32'(bus.isBeq_E),          32'(exp_e.beq));
            chk("isBgt_E",        32'(bus.isBgt_E),          32'(exp_e.bgt));
            chk("isUBranch_E",    32'(bus.isUBranch_E),      32'(exp_e.ubr));
            chk("isRet_E",        32'(bus.isRet_E),          32'(exp_e.ret));
            chk("isCall_E",       32'(bus.isCall_E),         32'(exp_e.call));
            chk("add_stall",      32'(bus.add_stall),        32'(mstall()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present an instruction the way fetch would: hold it while add_stall is up.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        bus.instruction_D = ins;
        bus.pc_D          = pc;
        #1;
        n = 0;
        while (bus.add_stall === 1'b1 && n < 3) begin
            tick();
            #1;
            n++;
        end
        if (n >= 3) begin
            fails++;
            $display("FAIL stall_bound: stall held %0d cycles, required at most 1", n);
        end
        tick();
    endtask

    task automatic wb(input logic [3:0] r, input logic [31:0] v);
        bus.regwrite_W = 1'b1;
        bus.rd_W       = r;
        bus.result_W   = v;
        issue(32'h6800_0000, 32'h0);
        bus.regwrite_W = 1'b0;
    endtask

    logic [31:0] dir_ins [14];

    initial begin
        tests = 0;
        fails = 0;
        chk_en = 0;
        rst = 1'b1;
        bus.interrupt = 1'b0;
        bus.isbranchtaken_E = 1'b0;
        bus.instruction_D = 32'h6800_0000;
        bus.pc_D = 32'h0;
        bus.regwrite_W = 1'b0;
        bus.rd_W = 4'd0;
        bus.result_W = 32'h0;

        // 1. reset
        tick();
        tick();
        chk_en = 1;
        chk("rst opcode_E", 32'(bus.opcode_E), 32'd13);
        chk("rst pc_E", bus.pc_E, 32'h0);
        chk("rst op1_E", bus.op1_E, 32'h0);
        chk("rst isWb_E", 32'(bus.isWb_E), 32'd0);
        chk("rst add_stall", 32'(bus.add_stall), 32'd0);
        rst = 1'b0;
        issue(32'h0438_0000, 32'h4);            // add r0,r14,#0
        chk("sp reset value", bus.op1_E, 32'h0000_0FFC);

        // 2. add r2,r1,#3 with r1=5
        wb(4'd1, 32'd5);
        issue(32'h0484_0003, 32'h100);
        chk("add op1_E", bus.op1_E, 32'd5);
        chk("add imm_E", bus.imm_E, 32'd3);
        chk("add isImmediate_E", 32'(bus.isImmediate_E), 32'd1);
        chk("add rd_E", 32'(bus.rd_E), 32'd2);
        chk("add isWb_E", 32'(bus.isWb_E), 32'd1);

        // 3. load-use
        bus.instruction_D = 32'h74C4_0000;
        tick();
        bus.instruction_D = 32'h010C_C000;
        #1;
        chk("lu add_stall", 32'(bus.add_stall), 32'd1);
        tick();
        chk("lu bubble opcode_E", 32'(bus.opcode_E), 32'd13);
        #1;
        chk("lu stall released", 32'(bus.add_stall), 32'd0);
        tick();
        chk("lu add issued opcode", 32'(bus.opcode_E), 32'd0);
        chk("lu add issued rd", 32'(bus.rd_E), 32'd4);

        // 4. branch target, then flush over a pending stall
        issue(32'h9000_0004, 32'h10);
        chk("b branchtarget_E", bus.branchtarget_E, 32'h20);
        chk("b isUBranch_E", 32'(bus.isUBranch_E), 32'd1);
        issue(32'h74C4_0000, 32'h14);
        bus.instruction_D = 32'h010C_C000;
        bus.isbranchtaken_E = 1'b1;
        #1;
        chk("bt add_stall", 32'(bus.add_stall), 32'd0);
        tick();
        chk("bt bubble opcode", 32'(bus.opcode_E), 32'd13);
        bus.isbranchtaken_E = 1'b0;
        bus.interrupt = 1'b1;
        bus.instruction_D = 32'h0484_0003;
        tick();
        chk("irq bubble isWb", 32'(bus.isWb_E), 32'd0);
        bus.interrupt = 1'b0;
        issue(32'h97FF_FFFF, 32'h0);            // b -1 from pc 0
        chk("b wrap target", bus.branchtarget_E, 32'hFFFF_FFFC);

        // 5. immediate modifiers
        issue(32'h4D41_FFFF, 32'h20);
        chk("imm zext", bus.imm_E, 32'h0000_FFFF);
        issue(32'h4D40_FFFF, 32'h24);
        chk("imm sext", bus.imm_E, 32'hFFFF_FFFF);
        issue(32'h4D42_FFFF, 32'h28);
        chk("imm high", bus.imm_E, 32'hFFFF_0000);

        // 6. same-cycle writeback of the register being read
        bus.instruction_D = 32'h0484_0003;
        bus.regwrite_W = 1'b1;
        bus.rd_W = 4'd1;
        bus.result_W = 32'd7;
        tick();
        bus.regwrite_W = 1'b0;
`ifdef REGFILE_BYPASS_EN
        chk("wb same cycle op1", bus.op1_E, 32'd7);
`else
        chk("wb same cycle op1", bus.op1_E, 32'd5);
`endif
        tick();
        chk("wb next cycle op1", bus.op1_E, 32'd7);

        // reset drops a simultaneous writeback and restores sp
        rst = 1'b1;
        bus.regwrite_W = 1'b1;
        bus.rd_W = 4'd14;
        bus.result_W = 32'h1234;
        bus.instruction_D = 32'h0438_0000;
        tick();
        rst = 1'b0;
        bus.regwrite_W = 1'b0;
        tick();
        chk("sp after rst+wb", bus.op1_E, 32'h0000_0FFC);
        issue(32'h0484_0003, 32'h30);
        chk("r1 cleared", bus.op1_E, 32'h0);

        // mixed sequence checked against the model
        wb(4'd1, 32'h10);
        wb(4'd3, 32'h33);
        wb(4'd15, 32'h200);
        dir_ins = '{32'h74C4_0000, 32'h7CC4_0000,   // ld r3 ; st r3 (stall on data)
                    32'h74C4_0000, 32'h4940_C000,   // ld r3 ; mov r5,r3 (stall)
                    32'h74C4_0000, 32'h4D40_FFFF,   // ld r3 ; mov r5,#imm (no stall)
                    32'h74C4_0000, 32'h280C_8000,   // ld r3 ; cmp r3,r2 (stall)
                    32'h77C4_0000, 32'hA000_0000,   // ld r15 ; ret (stall)
                    32'h9800_0010, 32'h8000_0008,   // call ; beq
                    32'h74C4_0000, 32'h900C_0000};  // ld r3 ; b (no stall)
        for (int i = 0; i < 14; i++) issue(dir_ins[i], 32'h40 + 32'(i * 4));
        issue(32'h8800_0003, 32'h80);           // bgt
        issue(32'h7CC4_0000, 32'h84);           // st r3
        chk("st rs2_E is data reg", 32'(bus.rs2_E), 32'd3);
        issue(32'hA000_0000, 32'h88);           // ret
        chk("ret rs1_E", 32'(bus.rs1_E), 32'd15);
        issue(32'h9800_0010, 32'h8C);           // call
        chk("call rd_E", 32'(bus.rd_E), 32'd15);
        tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
